discrete_range_sampler: RTL and testbench

//  Draws one random value for a discrete integer variable whose domain is a union of [start,end] ranges.
//  - Chooses a range index uniformly from 0..in_number_of_ranges-1.
//  - Reads that range's start/end from the discrete values table.
//  - Returns start + (rand mod (end-start+1)).
//  - Sits between the sampler control FSM and the discrete values table.

---
 rtl/discrete_sampler_pkg.sv | 24 ++
 rtl/seq_modulo.sv | 57 +++++
 rtl/discrete_range_sampler.sv | 135 +++++++++++++
 tb/tb_discrete_range_sampler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/discrete_sampler_pkg.sv
// Shared definitions for the discrete range sampler: state encoding, LFSR constants, default widths.
package discrete_sampler_pkg;

  localparam int DISCRETE_VARIABLE_INDEX_BIT_WIDTH = 4;
  localparam int DISCRETE_VALUES_NUMBER_BIT_WIDTH  = 4;
  localparam int BIT_WIDTH_OF_INTEGER_VARIABLE     = 16;

  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam logic [31:0] LFSR_RESET = 32'h0000_0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_LOOKUP,
    ST_OFFSET,
    ST_DONE
  } sampler_state_t;

  // Right-shifting Galois step; the tap word already carries bit 31 for the feedback.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/seq_modulo.sv
// Restoring remainder unit: one quotient bit per cycle, INT_W cycles from load to final remainder.
module seq_modulo #(
  parameter int INT_W = 16
) (
  input  logic             in_clk,
  input  logic             in_reset_n,
  input  logic             in_start,
  input  logic [INT_W-1:0] in_dividend,
  input  logic [INT_W:0]   in_divisor,
  output logic             out_busy,
  output logic             out_done,
  output logic [INT_W-1:0] out_remainder
);

  localparam int CNT_W = $clog2(INT_W + 1);

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [INT_W-1:0] dividend_q;
  logic [INT_W:0]   divisor_q;
  logic [INT_W:0]   rem_q;
  logic [INT_W:0]   shifted;
  logic [INT_W:0]   rem_next;

  // The remainder stays below the divisor (at most 2^INT_W), so INT_W+1 bits never overflow.
  always_comb begin
    shifted  = {rem_q[INT_W-1:0], dividend_q[INT_W-1]};
    rem_next = (shifted >= divisor_q) ? (shifted - divisor_q) : shifted;
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      active     <= 1'b0;
      cnt        <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
    end else if (in_start) begin
      active     <= 1'b1;
      cnt        <= CNT_W'(INT_W);
      dividend_q <= in_dividend;
      divisor_q  <= in_divisor;
      rem_q      <= '0;
    end else if (active) begin
      rem_q      <= rem_next;
      dividend_q <= dividend_q << 1;
      cnt        <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) active <= 1'b0;
    end
  end

  // Done flags the edge that lands the final remainder, so the caller can move on at that same edge.
  assign out_busy      = active;
  assign out_done      = active && (cnt == CNT_W'(1));
  assign out_remainder = rem_q[INT_W-1:0];

endmodule

// File: rtl/discrete_range_sampler.sv
// Draws one value for a discrete variable: uniform range pick, table lookup, uniform offset within the range.
module discrete_range_sampler
  import discrete_sampler_pkg::*;
#(
  parameter int VAR_IDX_W = DISCRETE_VARIABLE_INDEX_BIT_WIDTH,
  parameter int VAL_IDX_W = DISCRETE_VALUES_NUMBER_BIT_WIDTH,
  parameter int INT_W     = BIT_WIDTH_OF_INTEGER_VARIABLE
) (
  input  logic                 in_clk,
  input  logic                 in_reset_n,
  input  logic                 in_seed_load,
  input  logic [31:0]          in_seed,
  input  logic                 in_start,
  input  logic [VAR_IDX_W-1:0] in_variable_index,
  input  logic [VAL_IDX_W:0]   in_number_of_ranges,
  output logic [VAR_IDX_W-1:0] out_variable_index,
  output logic [VAL_IDX_W-1:0] out_index_of_the_discrete_value,
  input  logic [INT_W-1:0]     in_start_value,
  input  logic [INT_W-1:0]     in_end_value,
  output logic                 out_busy,
  output logic                 out_valid,
  input  logic                 in_ready,
  output logic [INT_W-1:0]     out_value,
  output logic                 out_error
);

  sampler_state_t       state, state_next;
  logic [31:0]          lfsr;
  logic [31:0]          lfsr_base;
  logic [31:0]          lfsr_draw;
  logic [VAR_IDX_W-1:0] var_idx_q;
  logic [VAL_IDX_W:0]   count_q;
  logic [INT_W-1:0]     start_q;
  logic                 err_q;
  logic [VAR_IDX_W-1:0] var_addr_q;
  logic [VAL_IDX_W-1:0] val_addr_q;
  logic                 no_ranges;
  logic                 range_bad;
  logic [INT_W:0]       range_width;
  logic                 mod_start;
  logic                 mod_busy;
  logic                 mod_done;
  logic [INT_W-1:0]     mod_dividend;
  logic [INT_W:0]       mod_divisor;
  logic [INT_W-1:0]     mod_rem;

  assign lfsr_base   = in_seed_load ? ((in_seed == 32'h0) ? LFSR_RESET : in_seed) : lfsr;
  assign lfsr_draw   = lfsr_step(lfsr);
  assign no_ranges   = (in_number_of_ranges == '0);
  assign range_bad   = (in_end_value < in_start_value);
  assign range_width = {1'b0, in_end_value} - {1'b0, in_start_value} + (INT_W+1)'(1);

  // PICK loads the divider in its first cycle from the already stepped LFSR; OFFSET is loaded
  // straight from LOOKUP with the next LFSR word and the live table width.
  always_comb begin
    state_next   = state;
    mod_start    = 1'b0;
    mod_dividend = lfsr[INT_W-1:0];
    mod_divisor  = (INT_W+1)'(count_q);
    case (state)
      ST_IDLE:   if (in_start) state_next = no_ranges ? ST_DONE : ST_PICK;
      ST_PICK: begin
        mod_start = !mod_busy;
        if (mod_done) state_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (range_bad) begin
          state_next = ST_DONE;
        end else begin
          mod_start    = 1'b1;
          mod_dividend = lfsr_draw[INT_W-1:0];
          mod_divisor  = range_width;
          state_next   = ST_OFFSET;
        end
      end
      ST_OFFSET: if (mod_done) state_next = ST_DONE;
      ST_DONE:   if (in_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state      <= ST_IDLE;
      lfsr       <= LFSR_RESET;
      var_idx_q  <= '0;
      count_q    <= '0;
      start_q    <= '0;
      err_q      <= 1'b0;
      var_addr_q <= '0;
      val_addr_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          lfsr <= lfsr_base;
          if (in_start) begin
            var_idx_q <= in_variable_index;
            count_q   <= in_number_of_ranges;
            err_q     <= no_ranges;
            if (!no_ranges) lfsr <= lfsr_step(lfsr_base);
          end
        end
        ST_LOOKUP: begin
          start_q    <= in_start_value;
          err_q      <= range_bad;
          var_addr_q <= var_idx_q;
          val_addr_q <= mod_rem[VAL_IDX_W-1:0];
          if (!range_bad) lfsr <= lfsr_draw;
        end
        default: ;
      endcase
    end
  end

  seq_modulo #(.INT_W(INT_W)) u_modulo (
    .in_clk        (in_clk),
    .in_reset_n    (in_reset_n),
    .in_start      (mod_start),
    .in_dividend   (mod_dividend),
    .in_divisor    (mod_divisor),
    .out_busy      (mod_busy),
    .out_done      (mod_done),
    .out_remainder (mod_rem)
  );

  // The divider keeps the offset remainder until the next draw, so DONE can add it combinationally.
  assign out_variable_index              = (state == ST_LOOKUP) ? var_idx_q : var_addr_q;
  assign out_index_of_the_discrete_value = (state == ST_LOOKUP) ? mod_rem[VAL_IDX_W-1:0] : val_addr_q;
  assign out_busy  = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_error = (state == ST_DONE) && err_q;
  assign out_value = ((state == ST_DONE) && !err_q) ? (start_q + mod_rem) : '0;

endmodule

// File: tb/tb_discrete_range_sampler.sv
// Scoreboard bench for discrete_range_sampler with a behavioural LFSR/modulo model and a table model.
module tb_discrete_range_sampler;

  localparam int VAR_IDX_W = 4;
  localparam int VAL_IDX_W = 4;
  localparam int INT_W     = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 seed_load;
  logic [31:0]          seed;
  logic                 start;
  logic [VAR_IDX_W-1:0] var_idx;
  logic [VAL_IDX_W:0]   num_ranges;
  logic [VAR_IDX_W-1:0] out_var;
  logic [VAL_IDX_W-1:0] out_val_idx;
  logic [INT_W-1:0]     start_value;
  logic [INT_W-1:0]     end_value;
  logic                 busy;
  logic                 valid;
  logic                 rdy;
  logic [INT_W-1:0]     value;
  logic                 error;

  logic [INT_W-1:0] start_tbl [0:15][0:15];
  logic [INT_W-1:0] end_tbl   [0:15][0:15];

  typedef struct {
    logic [INT_W-1:0]     value;
    logic                 err;
    int                   lat;
    logic                 chk_addr;
    logic [VAR_IDX_W-1:0] var_idx;
    logic [VAL_IDX_W-1:0] val_idx;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_lfsr;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          rise_cyc = 0;
  int          hit0, hit1, hit2;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign start_value = start_tbl[out_var][out_val_idx];
  assign end_value   = end_tbl[out_var][out_val_idx];

  discrete_range_sampler #(
    .VAR_IDX_W(VAR_IDX_W), .VAL_IDX_W(VAL_IDX_W), .INT_W(INT_W)
  ) dut (
    .in_clk                          (clk),
    .in_reset_n                      (rst_n),
    .in_seed_load                    (seed_load),
    .in_seed                         (seed),
    .in_start                        (start),
    .in_variable_index               (var_idx),
    .in_number_of_ranges             (num_ranges),
    .out_variable_index              (out_var),
    .out_index_of_the_discrete_value (out_val_idx),
    .in_start_value                  (start_value),
    .in_end_value                    (end_value),
    .out_busy                        (busy),
    .out_valid                       (valid),
    .in_ready                        (rdy),
    .out_value                       (value),
    .out_error                       (error)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_step(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  // Reference draw: advances m_lfsr exactly as many times as the hardware should.
  task automatic model_draw(input logic [VAR_IDX_W-1:0] vi, input logic [VAL_IDX_W:0] nr, output exp_t e);
    logic [31:0] r, s, en, w, off;
    e.value = '0; e.err = 1'b0; e.lat = 0; e.chk_addr = 1'b0; e.var_idx = vi; e.val_idx = '0;
    if (nr == 0) begin
      e.err = 1'b1;
      e.lat = 0;
    end else begin
      m_lfsr = model_step(m_lfsr);
      r = {16'h0, m_lfsr[15:0]} % {27'h0, nr};
      e.chk_addr = 1'b1;
      e.val_idx = r[VAL_IDX_W-1:0];
      s  = {16'h0, start_tbl[vi][r[3:0]]};
      en = {16'h0, end_tbl[vi][r[3:0]]};
      if (en < s) begin
        e.err = 1'b1;
        e.lat = INT_W + 2;
      end else begin
        m_lfsr = model_step(m_lfsr);
        w   = en - s + 32'd1;
        off = {16'h0, m_lfsr[15:0]} % w;
        e.value = INT_W'(s + off);
        e.lat = 2 * INT_W + 2;
      end
    end
  endtask

  // Called at a negedge: queues the expected result and issues one start pulse.
  task automatic apply_stimulus(input logic [VAR_IDX_W-1:0] vi, input logic [VAL_IDX_W:0] nr,
                                input logic sl, input logic [31:0] sd);
    exp_t e;
    if (sl) m_lfsr = (sd == 32'h0) ? 32'h1 : sd;
    model_draw(vi, nr, e);
    sb.push_back(e);
    seed_load = sl; seed = sd; var_idx = vi; num_ranges = nr; start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0; seed_load = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      bad++; total++;
      $display("[TB] FAIL result_timeout: actual=%0d pending required=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // Monitor: latency is taken at the rising edge of valid, the comparison at the handshake.
  initial begin : monitor
    exp_t e;
    logic valid_d;
    valid_d = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        valid_d = 1'b0;
      end else begin
        if (valid && !valid_d) rise_cyc = cyc;
        if (valid && rdy) begin
          if (sb.size() == 0) begin
            bad++; total++;
            $display("[TB] FAIL unexpected_result: actual=%0h required=none", value);
          end else begin
            e = sb.pop_front();
            check_output("value", {16'h0, value}, {16'h0, e.value});
            check_output("error", {31'h0, error}, {31'h0, e.err});
            check_output("latency", rise_cyc - start_cyc, e.lat);
            if (e.chk_addr) begin
              check_output("addr_var", {28'h0, out_var}, {28'h0, e.var_idx});
              check_output("addr_val", {28'h0, out_val_idx}, {28'h0, e.val_idx});
            end
            if (value <= 16'd9) hit0++;
            else if (value == 16'd100) hit1++;
            else if (value >= 16'd200 && value <= 16'd299) hit2++;
          end
        end
        valid_d = valid;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : stimulus
    int n;
    for (int v = 0; v < 16; v++)
      for (int r = 0; r < 16; r++) begin
        start_tbl[v][r] = '0;
        end_tbl[v][r]   = '0;
      end
    start_tbl[0][0] = 16'd5;     end_tbl[0][0] = 16'd5;
    start_tbl[1][0] = 16'd0;     end_tbl[1][0] = 16'd9;
    start_tbl[1][1] = 16'd100;   end_tbl[1][1] = 16'd100;
    start_tbl[1][2] = 16'd200;   end_tbl[1][2] = 16'd299;
    start_tbl[2][0] = 16'd7;     end_tbl[2][0] = 16'd3;
    start_tbl[3][0] = 16'd0;     end_tbl[3][0] = 16'hFFFF;
    start_tbl[4][0] = 16'hFFFA;  end_tbl[4][0] = 16'hFFFF;
    for (int r = 0; r < 16; r++) begin
      start_tbl[6][r] = 16'(r * 10);
      end_tbl[6][r]   = 16'(r * 10 + 3);
    end

    rst_n = 1'b0; seed_load = 1'b0; seed = '0; start = 1'b0;
    var_idx = '0; num_ranges = '0; rdy = 1'b1;
    m_lfsr = 32'h1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_valid", {31'h0, valid}, 32'h0);
    check_output("reset_busy", {31'h0, busy}, 32'h0);
    check_output("reset_value", {16'h0, value}, 32'h0);
    check_output("reset_error", {31'h0, error}, 32'h0);
    check_output("reset_addr", {24'h0, out_var, out_val_idx}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-point range, seed 0 loaded together with start (becomes 1).
    apply_stimulus(4'd0, 5'd1, 1'b1, 32'h0);
    wait_drain(200);

    // Zero ranges and an inverted range both report errors.
    apply_stimulus(4'd5, 5'd0, 1'b0, 32'h0);
    wait_drain(200);
    apply_stimulus(4'd2, 5'd1, 1'b0, 32'h0);
    wait_drain(200);

    // Full-width range, with a start pulse while busy that must not produce a result.
    apply_stimulus(4'd3, 5'd1, 1'b0, 32'h0);
    repeat (5) @(negedge clk);
    check_output("busy_mid_draw", {31'h0, busy}, 32'h1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain(200);
    repeat (60) @(negedge clk);

    // Range at the top of the integer space.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(4'd4, 5'd1, 1'b0, 32'h0);
      wait_drain(200);
    end

    // Maximum range count.
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(4'd6, 5'd16, 1'b0, 32'h0);
      wait_drain(200);
    end

    // 1000 draws over three ranges from seed ACE1.
    hit0 = 0; hit1 = 0; hit2 = 0;
    apply_stimulus(4'd1, 5'd3, 1'b1, 32'h0000_ACE1);
    wait_drain(200);
    for (int i = 1; i < 1000; i++) begin
      apply_stimulus(4'd1, 5'd3, 1'b0, 32'h0);
      wait_drain(200);
    end
    check_output("range0_hit", {31'h0, hit0 > 0}, 32'h1);
    check_output("range1_hit", {31'h0, hit1 > 0}, 32'h1);
    check_output("range2_hit", {31'h0, hit2 > 0}, 32'h1);
    check_output("hits_total", hit0 + hit1 + hit2, 1000);

    // Consumer stall: result held, then start during the handoff edge is ignored.
    rdy = 1'b0;
    apply_stimulus(4'd0, 5'd1, 1'b0, 32'h0);
    n = 0;
    while (!valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("stall_valid_seen", {31'h0, valid}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("stall_valid", {31'h0, valid}, 32'h1);
      check_output("stall_value", {16'h0, value}, 32'd5);
    end
    @(posedge clk);
    #1;
    rdy = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check_output("valid_low_after_ready", {31'h0, valid}, 32'h0);
    check_output("idle_after_handoff", {31'h0, busy}, 32'h0);
    wait_drain(200);
    repeat (60) @(negedge clk);

    // Reset in the middle of OFFSET, then a bit-exact draw from seed 1.
    apply_stimulus(4'd3, 5'd1, 1'b1, 32'h1234_5678);
    repeat (INT_W + 6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("rst_mid_valid", {31'h0, valid}, 32'h0);
    check_output("rst_mid_busy", {31'h0, busy}, 32'h0);
    check_output("rst_mid_value", {16'h0, value}, 32'h0);
    check_output("rst_mid_error", {31'h0, error}, 32'h0);
    sb.delete();
    m_lfsr = 32'h1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(4'd1, 5'd3, 1'b0, 32'h0);
    wait_drain(200);
    apply_stimulus(4'd3, 5'd1, 1'b0, 32'h0);
    wait_drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
